// File: rtl/mops_sdo_responder.sv
`timescale 1ns/1ps
// Emulated MOPS CANopen node answering MOPSHUB expedited SDO requests; MOPS_SDO_DOWNLOAD_EN adds 8 writable scratch registers.
// Latency: response valid 2+RSP_DELAY cycles after request accept; response held until rsp_ready, no requests taken while busy.
module mops_sdo_responder #(
    parameter logic [6:0] NODE_ID   = 7'h00,
    parameter int         RSP_DELAY = 16,
    parameter int         N_ADC_CH  = 32
) (
    input  logic        clk_40_m,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [75:0] req_frame,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [75:0] rsp_frame,
    output logic        busy,
    output logic [7:0]  ignore_cnt,
    output logic [7:0]  abort_cnt
);
    typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, WAIT = 2'd2, SEND = 2'd3} state_t;

    localparam logic [10:0] REQ_COB = 11'h600 + {4'h0, NODE_ID};
    localparam logic [10:0] RSP_COB = 11'h580 + {4'h0, NODE_ID};

    state_t      state_q, state_d;
    logic [31:0] req_q, req_d;          // cmd, idx lo, idx hi, subidx of the accepted request
    logic [75:0] rsp_q, rsp_d;
    logic [7:0]  dly_q, dly_d;
    logic [7:0]  ign_q, ign_d;
    logic [7:0]  abt_q, abt_d;
    logic [11:0] adc_base_q, adc_base_d;
    logic        is_adc_q, is_adc_d;
    logic        is_abort_q, is_abort_d;

    logic [7:0]  cmd;
    logic [15:0] idx;
    logic [7:0]  sub;
    logic [11:0] adc_val;
    logic        sub_is_adc;
    logic [7:0]  r_cmd;
    logic [31:0] r_dat;
    logic        unused_bits;

    assign cmd        = req_q[31:24];
    assign idx        = {req_q[15:8], req_q[23:16]};
    assign sub        = req_q[7:0];
    assign adc_val    = adc_base_q + {4'h0, sub};
    assign sub_is_adc = {1'b0, sub} < 9'(N_ADC_CH);

`ifdef MOPS_SDO_DOWNLOAD_EN
    logic [15:0] scratch_q [8];
    logic [15:0] scratch_d [8];
    logic [15:0] wr_dat_q, wr_dat_d;
    assign unused_bits = ^req_frame[15:0];
`else
    assign unused_bits = ^req_frame[31:0];
`endif

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        rsp_d      = rsp_q;
        dly_d      = dly_q;
        ign_d      = ign_q;
        abt_d      = abt_q;
        adc_base_d = adc_base_q;
        is_adc_d   = is_adc_q;
        is_abort_d = is_abort_q;
        r_cmd      = 8'h80;
        r_dat      = 32'h01000405;
`ifdef MOPS_SDO_DOWNLOAD_EN
        wr_dat_d   = wr_dat_q;
        for (int i = 0; i < 8; i++) scratch_d[i] = scratch_q[i];
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_frame[75:65] == REQ_COB && !req_frame[64]) begin
                        req_d   = req_frame[63:32];
`ifdef MOPS_SDO_DOWNLOAD_EN
                        wr_dat_d = {req_frame[23:16], req_frame[31:24]};
`endif
                        state_d = CHECK;
                    end else if (ign_q != 8'hFF) begin
                        ign_d = ign_q + 8'd1;
                    end
                end
            end
            CHECK: begin
                // Default answer is the "command unknown" abort; data bytes are little-endian
                is_adc_d   = 1'b0;
                is_abort_d = 1'b1;
                if (cmd == 8'h40) begin
                    if (idx == 16'h2400 && sub_is_adc) begin
                        r_cmd      = 8'h4B;
                        r_dat      = {adc_val[7:0], 4'h0, adc_val[11:8], 16'h0000};
                        is_adc_d   = 1'b1;
                        is_abort_d = 1'b0;
                    end else if (idx == 16'h1000 && sub == 8'h00) begin
                        r_cmd      = 8'h43;
                        r_dat      = 32'h91010000;
                        is_abort_d = 1'b0;
`ifdef MOPS_SDO_DOWNLOAD_EN
                    end else if (idx == 16'h2200 && sub < 8'd8) begin
                        r_cmd      = 8'h4B;
                        r_dat      = {scratch_q[sub[2:0]][7:0], scratch_q[sub[2:0]][15:8], 16'h0000};
                        is_abort_d = 1'b0;
`endif
                    end else begin
                        r_dat = 32'h00000206;
                    end
`ifdef MOPS_SDO_DOWNLOAD_EN
                end else if (cmd == 8'h2B) begin
                    if (idx == 16'h2200 && sub < 8'd8) begin
                        r_cmd                = 8'h60;
                        r_dat                = 32'h0;
                        is_abort_d           = 1'b0;
                        scratch_d[sub[2:0]]  = wr_dat_q;
                    end else begin
                        r_dat = 32'h00000206;
                    end
`endif
                end
                rsp_d   = {RSP_COB, 1'b0, r_cmd, req_q[23:0], r_dat};
                dly_d   = 8'(RSP_DELAY);
                state_d = WAIT;
            end
            WAIT: begin
                if (dly_q == 8'd0) state_d = SEND;
                else               dly_d   = dly_q - 8'd1;
            end
            SEND: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    if (is_adc_q) adc_base_d = adc_base_q + 12'd1;
                    if (is_abort_q && abt_q != 8'hFF) abt_d = abt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_40_m) begin
        if (!rst) begin
            state_q    <= IDLE;
            req_q      <= '0;
            rsp_q      <= '0;
            dly_q      <= '0;
            ign_q      <= '0;
            abt_q      <= '0;
            adc_base_q <= 12'h000;
            is_adc_q   <= 1'b0;
            is_abort_q <= 1'b0;
`ifdef MOPS_SDO_DOWNLOAD_EN
            wr_dat_q   <= '0;
            for (int i = 0; i < 8; i++) scratch_q[i] <= 16'h0000;
`endif
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            rsp_q      <= rsp_d;
            dly_q      <= dly_d;
            ign_q      <= ign_d;
            abt_q      <= abt_d;
            adc_base_q <= adc_base_d;
            is_adc_q   <= is_adc_d;
            is_abort_q <= is_abort_d;
`ifdef MOPS_SDO_DOWNLOAD_EN
            wr_dat_q   <= wr_dat_d;
            for (int i = 0; i < 8; i++) scratch_q[i] <= scratch_d[i];
`endif
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign rsp_valid  = (state_q == SEND);
    assign busy       = (state_q != IDLE);
    assign rsp_frame  = rsp_q;
    assign ignore_cnt = ign_q;
    assign abort_cnt  = abt_q;
endmodule

// File: tb/tb_mops_sdo_responder.sv
`timescale 1ns/1ps
// Directed bench for mops_sdo_responder (NODE_ID=0, RSP_DELAY=16, N_ADC_CH=32): vector table plus back-pressure and reset corner cases.
module tb_mops_sdo_responder;
    logic        clk_40_m = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [75:0] req_frame = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [75:0] rsp_frame;
    logic        busy;
    logic [7:0]  ignore_cnt;
    logic [7:0]  abort_cnt;

    int errors = 0;
    int checks = 0;

    mops_sdo_responder #(.NODE_ID(7'h00), .RSP_DELAY(16), .N_ADC_CH(32)) dut (
        .clk_40_m(clk_40_m), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_frame(req_frame),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_frame(rsp_frame),
        .busy(busy), .ignore_cnt(ignore_cnt), .abort_cnt(abort_cnt)
    );

    always #12.5 clk_40_m = ~clk_40_m;

    typedef struct {
        logic [10:0] cob;
        logic        rtr;
        logic [7:0]  cmd;
        logic [15:0] idx;
        logic [7:0]  sub;
        logic [31:0] dat;
        logic        rsp;
        logic [7:0]  e_cmd;
        logic [31:0] e_dat;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [75:0] act, input logic [75:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [75:0] mk(input logic [10:0] cob, input logic rtr, input logic [7:0] cmd,
                                       input logic [15:0] idx, input logic [7:0] sub, input logic [31:0] dat);
        return {cob, rtr, cmd, idx[7:0], idx[15:8], sub, dat};
    endfunction

    task automatic tick();
        @(posedge clk_40_m);
        #1;
    endtask

    task automatic send(input logic [75:0] f);
        req_frame = f;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = 0;
        while (!rsp_valid && cyc < 100) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        int          exp_ign;
        int          exp_abt;
        logic        seen;
        logic        stable;
        logic [75:0] snap;
        logic [75:0] exp_f;

        exp_ign = 0;
        exp_abt = 0;
        tbl[0]  = '{11'h600, 1'b0, 8'h40, 16'h2400, 8'h05, 32'h0, 1'b1, 8'h4B, 32'h05000000};
        tbl[1]  = '{11'h600, 1'b0, 8'h40, 16'h2400, 8'h05, 32'h0, 1'b1, 8'h4B, 32'h06000000};
        tbl[2]  = '{11'h601, 1'b0, 8'h40, 16'h2400, 8'h05, 32'h0, 1'b0, 8'h00, 32'h0};
        tbl[3]  = '{11'h600, 1'b0, 8'h40, 16'h2400, 8'h20, 32'h0, 1'b1, 8'h80, 32'h00000206};
        tbl[4]  = '{11'h600, 1'b0, 8'h22, 16'h2400, 8'h05, 32'h0, 1'b1, 8'h80, 32'h01000405};
        tbl[5]  = '{11'h600, 1'b0, 8'h40, 16'h1000, 8'h00, 32'h0, 1'b1, 8'h43, 32'h91010000};
        tbl[6]  = '{11'h600, 1'b1, 8'h40, 16'h2400, 8'h05, 32'h0, 1'b0, 8'h00, 32'h0};
        tbl[7]  = '{11'h600, 1'b0, 8'h40, 16'h2400, 8'h1F, 32'h0, 1'b1, 8'h4B, 32'h21000000};
`ifdef MOPS_SDO_DOWNLOAD_EN
        tbl[8]  = '{11'h600, 1'b0, 8'h2B, 16'h2200, 8'h03, 32'hEFBE0000, 1'b1, 8'h60, 32'h0};
        tbl[9]  = '{11'h600, 1'b0, 8'h40, 16'h2200, 8'h03, 32'h0, 1'b1, 8'h4B, 32'hEFBE0000};
`else
        tbl[8]  = '{11'h600, 1'b0, 8'h2B, 16'h2200, 8'h03, 32'hEFBE0000, 1'b1, 8'h80, 32'h01000405};
        tbl[9]  = '{11'h600, 1'b0, 8'h40, 16'h2200, 8'h03, 32'h0, 1'b1, 8'h80, 32'h00000206};
`endif
        tbl[10] = '{11'h600, 1'b0, 8'h40, 16'h2400, 8'h00, 32'h0, 1'b1, 8'h4B, 32'h03000000};

        // Reset state
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("rst_req_ready", 76'(req_ready), 76'(1));
        chk("rst_rsp_valid", 76'(rsp_valid), 76'(0));
        chk("rst_busy", 76'(busy), 76'(0));
        chk("rst_ignore_cnt", 76'(ignore_cnt), 76'(0));
        chk("rst_abort_cnt", 76'(abort_cnt), 76'(0));
        chk("rst_rsp_frame", rsp_frame, 76'(0));

        for (int i = 0; i < 11; i++) begin
            send(mk(tbl[i].cob, tbl[i].rtr, tbl[i].cmd, tbl[i].idx, tbl[i].sub, tbl[i].dat));
            if (tbl[i].rsp) begin
                chk($sformatf("v%0d_busy", i), 76'(busy), 76'(1));
                wait_rsp(cyc);
                chk($sformatf("v%0d_latency", i), 76'(cyc), 76'(18));
                exp_f = mk(11'h580, 1'b0, tbl[i].e_cmd, tbl[i].idx, tbl[i].sub, tbl[i].e_dat);
                chk($sformatf("v%0d_frame", i), rsp_frame, exp_f);
                if (tbl[i].e_cmd == 8'h80) exp_abt++;
                rsp_ready = 1'b1;
                tick();
                rsp_ready = 1'b0;
                chk($sformatf("v%0d_idle", i), 76'({busy, rsp_valid, req_ready}), 76'(3'b001));
            end else begin
                exp_ign++;
                seen = 1'b0;
                repeat (25) begin
                    if (rsp_valid || busy) seen = 1'b1;
                    tick();
                end
                chk($sformatf("v%0d_no_rsp", i), 76'(seen), 76'(0));
            end
            chk($sformatf("v%0d_ignore_cnt", i), 76'(ignore_cnt), 76'(exp_ign));
            chk($sformatf("v%0d_abort_cnt", i), 76'(abort_cnt), 76'(exp_abt));
        end

        // Back-pressure plus a request pulsed while in WAIT; adc_base is now 4
        send(mk(11'h600, 1'b0, 8'h40, 16'h2400, 8'h00, 32'h0));
        repeat (5) tick();
        chk("wait_req_ready", 76'(req_ready), 76'(0));
        send(mk(11'h601, 1'b0, 8'h22, 16'h0000, 8'h00, 32'h0));
        chk("wait_pulse_ignore_cnt", 76'(ignore_cnt), 76'(exp_ign));
        wait_rsp(cyc);
        chk("bp_latency_rest", 76'(cyc), 76'(12));
        exp_f = mk(11'h580, 1'b0, 8'h4B, 16'h2400, 8'h00, 32'h04000000);
        chk("bp_frame", rsp_frame, exp_f);
        snap   = rsp_frame;
        stable = 1'b1;
        repeat (50) begin
            tick();
            if (rsp_frame !== snap || !rsp_valid) stable = 1'b0;
        end
        chk("bp_stable_50", 76'(stable), 76'(1));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp_idle", 76'({busy, rsp_valid, req_ready}), 76'(3'b001));

        // Reset while in WAIT drops the pending request
        send(mk(11'h600, 1'b0, 8'h40, 16'h2400, 8'h01, 32'h0));
        repeat (4) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mrst_outputs", 76'({busy, rsp_valid, req_ready}), 76'(3'b001));
        chk("mrst_counters", 76'({ignore_cnt, abort_cnt}), 76'(0));
        chk("mrst_rsp_frame", rsp_frame, 76'(0));
        seen = 1'b0;
        repeat (40) begin
            if (rsp_valid) seen = 1'b1;
            tick();
        end
        chk("mrst_no_rsp", 76'(seen), 76'(0));

        // adc_base restarts from 0 after reset
        send(mk(11'h600, 1'b0, 8'h40, 16'h2400, 8'h05, 32'h0));
        wait_rsp(cyc);
        chk("post_rst_latency", 76'(cyc), 76'(18));
        exp_f = mk(11'h580, 1'b0, 8'h4B, 16'h2400, 8'h05, 32'h05000000);
        chk("post_rst_frame", rsp_frame, exp_f);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("post_rst_idle", 76'({busy, rsp_valid, req_ready}), 76'(3'b001));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
